// File: rtl/mole_arena_if.sv
// Signal bundle between the whack-a-mole game core and its surroundings:
// keypad hits and tick pulses in, grid map, score and game status out.
interface mole_arena_if #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int GAME_SECS    = 60,
    parameter int SCORE_DIGITS = 3
);
    localparam int N  = ROWS * COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(GAME_SECS + 1);

    logic                      tick_sec;
    logic                      tick_step;
    logic                      start;
    logic                      mode;
    logic                      hit_valid;
    logic [CW-1:0]             hit_cell;
    logic [N-1:0]              mole_map;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic [TW-1:0]             time_left;
    logic [7:0]                miss_count;
    logic                      playing;
    logic                      game_over;
    logic                      hit_ack;
    logic                      hit_good;

    modport slave (
        input  tick_sec, tick_step, start, mode, hit_valid, hit_cell,
        output mole_map, score_bcd, time_left, miss_count,
               playing, game_over, hit_ack, hit_good
    );

    modport master (
        output tick_sec, tick_step, start, mode, hit_valid, hit_cell,
        input  mole_map, score_bcd, time_left, miss_count,
               playing, game_over, hit_ack, hit_good
    );
endinterface

// File: rtl/mole_arena.sv
// Whack-a-mole game core: mole slots with ageing/expiry, LFSR spawning,
// BCD scoring, miss counting and timed/survival game control on one clock.
module mole_arena #(
    parameter int          ROWS         = 4,
    parameter int          COLS         = 4,
    parameter int          MOLES        = 2,
    parameter int          LIFE_TICKS   = 8,
    parameter int          GAME_SECS    = 60,
    parameter int          MISS_LIMIT   = 5,
    parameter int          SCORE_DIGITS = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    mole_arena_if.slave   bus
);
    localparam int N  = ROWS * COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(GAME_SECS + 1);
    localparam int AW = (LIFE_TICKS > 1) ? $clog2(LIFE_TICKS) : 1;
    localparam int SW = 4 * SCORE_DIGITS;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [MOLES-1:0] valid_q, valid_d;
    logic [CW-1:0]   cell_q [MOLES];
    logic [CW-1:0]   cell_d [MOLES];
    logic [AW-1:0]   age_q  [MOLES];
    logic [AW-1:0]   age_d  [MOLES];
    logic [N-1:0]    map_q, map_d;
    logic [SW-1:0]   score_q, score_d;
    logic [TW-1:0]   time_q, time_d;
    logic [7:0]      miss_q, miss_d;
    logic            ack_q, ack_d;
    logic            good_q, good_d;
    logic [CW-1:0]   cand;
    logic            spawn_done;

    // Increment a BCD value, holding at all nines instead of wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        logic          sat;
        r     = v;
        carry = 1'b1;
        sat   = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            sat = sat & (v[4*i +: 4] == 4'd9);
        end
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return sat ? v : r;
    endfunction

    assign cand = lfsr_q[CW-1:0];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        valid_d    = valid_q;
        cell_d     = cell_q;
        age_d      = age_q;
        score_d    = score_q;
        time_d     = time_q;
        miss_d     = miss_q;
        ack_d      = 1'b0;
        good_d     = 1'b0;
        spawn_done = 1'b0;
        map_d      = '0;

        unique case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = PLAY;
                    mode_d  = bus.mode;
                    valid_d = '0;
                    score_d = '0;
                    miss_d  = '0;
                    time_d  = TW'(GAME_SECS);
                end
            end
            PLAY: begin
                if (bus.hit_valid) begin
                    ack_d = 1'b1;
                    for (int i = 0; i < MOLES; i++) begin
                        if (valid_q[i] && cell_q[i] == bus.hit_cell) begin
                            valid_d[i] = 1'b0;
                            good_d     = 1'b1;
                        end
                    end
                    if (good_d) begin
                        score_d = bcd_inc(score_q);
                    end
                end
                // A slot already cleared by this cycle's hit must not also expire.
                if (bus.tick_step) begin
                    for (int i = 0; i < MOLES; i++) begin
                        if (valid_q[i] && valid_d[i]) begin
                            if (age_q[i] == AW'(LIFE_TICKS - 1)) begin
                                valid_d[i] = 1'b0;
                                if (miss_d != 8'hFF) begin
                                    miss_d = miss_d + 8'd1;
                                end
                            end else begin
                                age_d[i] = age_q[i] + AW'(1);
                            end
                        end
                    end
                    for (int i = 0; i < MOLES; i++) begin
                        if (!spawn_done && !valid_q[i]) begin
                            spawn_done = 1'b1;
                            if ((int'(cand) < N) && !map_q[cand]) begin
                                valid_d[i] = 1'b1;
                                cell_d[i]  = cand;
                                age_d[i]   = '0;
                            end
                        end
                    end
                end
                if (bus.tick_sec && !mode_q && time_q != '0) begin
                    time_d = time_q - TW'(1);
                end
                if ((!mode_q && time_d == '0) || (mode_q && miss_d >= 8'(MISS_LIMIT))) begin
                    state_d = OVER;
                    valid_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < MOLES; i++) begin
            if (valid_d[i]) begin
                map_d = map_d | (N'(1) << cell_d[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            valid_q <= '0;
            for (int i = 0; i < MOLES; i++) begin
                cell_q[i] <= '0;
                age_q[i]  <= '0;
            end
            map_q   <= '0;
            score_q <= '0;
            time_q  <= TW'(GAME_SECS);
            miss_q  <= '0;
            ack_q   <= 1'b0;
            good_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            cell_q  <= cell_d;
            age_q   <= age_d;
            map_q   <= map_d;
            score_q <= score_d;
            time_q  <= time_d;
            miss_q  <= miss_d;
            ack_q   <= ack_d;
            good_q  <= good_d;
        end
    end

    assign bus.mole_map   = map_q;
    assign bus.score_bcd  = score_q;
    assign bus.time_left  = time_q;
    assign bus.miss_count = miss_q;
    assign bus.playing    = (state_q == PLAY);
    assign bus.game_over  = (state_q == OVER);
    assign bus.hit_ack    = ack_q;
    assign bus.hit_good   = good_q;
endmodule

// File: tb/tb_mole_arena.sv
// Bench for mole_arena: directed game scenarios plus random play, every cycle
// compared against an integer-level model of the game rules.
module tb_mole_arena;
    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int MOLES        = 2;
    localparam int LIFE_TICKS   = 3;
    localparam int GAME_SECS    = 3;
    localparam int MISS_LIMIT   = 2;
    localparam int SCORE_DIGITS = 3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int N         = ROWS * COLS;
    localparam int CW        = (N > 1) ? $clog2(N) : 1;
    localparam int SCORE_MAX = 999;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mole_arena_if #(.ROWS(ROWS), .COLS(COLS), .GAME_SECS(GAME_SECS),
                    .SCORE_DIGITS(SCORE_DIGITS)) bus ();

    mole_arena #(
        .ROWS(ROWS), .COLS(COLS), .MOLES(MOLES), .LIFE_TICKS(LIFE_TICKS),
        .GAME_SECS(GAME_SECS), .MISS_LIMIT(MISS_LIMIT),
        .SCORE_DIGITS(SCORE_DIGITS), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference game state, kept as plain integers and flags.
    bit          mPlay, mOver, mMode, mAck, mGood;
    int          mScore, mMiss, mTime;
    bit          mValid [MOLES];
    int          mCell  [MOLES];
    int          mAge   [MOLES];
    logic [15:0] mLfsr;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        int          taps [4] = '{16, 14, 13, 11};
        logic [15:0] mask;
        mask = '0;
        foreach (taps[t]) mask[taps[t] - 1] = 1'b1;
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    function automatic int liveCell();
        int c;
        c = -1;
        for (int i = 0; i < MOLES; i++) if (mValid[i] && c < 0) c = mCell[i];
        return c;
    endfunction

    task automatic modelReset();
        mPlay = 0; mOver = 0; mMode = 0; mAck = 0; mGood = 0;
        mScore = 0; mMiss = 0; mTime = GAME_SECS; mLfsr = LFSR_SEED;
        for (int i = 0; i < MOLES; i++) begin
            mValid[i] = 0; mCell[i] = 0; mAge[i] = 0;
        end
    endtask

    task automatic modelStep(input bit tSec, input bit tStep, input bit st,
                             input bit md, input bit hv, input int hc);
        int cand;
        int hitSlot;
        bit spawned;
        bit occ [N];
        bit wasValid [MOLES];
        cand  = int'(mLfsr) % (1 << CW);
        mLfsr = lfsrNext(mLfsr);
        mAck  = 0;
        mGood = 0;
        if (!mPlay) begin
            if (st) begin
                mPlay = 1; mOver = 0; mMode = md;
                mScore = 0; mMiss = 0; mTime = GAME_SECS;
                for (int i = 0; i < MOLES; i++) mValid[i] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) occ[c] = 0;
            for (int i = 0; i < MOLES; i++) begin
                wasValid[i] = mValid[i];
                if (mValid[i]) occ[mCell[i]] = 1;
            end
            hitSlot = -1;
            if (hv) begin
                mAck = 1;
                for (int i = 0; i < MOLES; i++)
                    if (wasValid[i] && mCell[i] == hc) hitSlot = i;
                if (hitSlot >= 0) begin
                    mGood = 1;
                    mValid[hitSlot] = 0;
                    if (mScore < SCORE_MAX) mScore++;
                end
            end
            if (tStep) begin
                for (int i = 0; i < MOLES; i++) begin
                    if (wasValid[i] && i != hitSlot) begin
                        if (mAge[i] == LIFE_TICKS - 1) begin
                            mValid[i] = 0;
                            if (mMiss < 255) mMiss++;
                        end else begin
                            mAge[i]++;
                        end
                    end
                end
                spawned = 0;
                for (int i = 0; i < MOLES; i++) begin
                    if (!spawned && !wasValid[i]) begin
                        spawned = 1;
                        if (cand < N && !occ[cand]) begin
                            mValid[i] = 1; mCell[i] = cand; mAge[i] = 0;
                        end
                    end
                end
            end
            if (tSec && !mMode && mTime > 0) mTime--;
            if ((!mMode && mTime == 0) || (mMode && mMiss >= MISS_LIMIT)) begin
                mPlay = 0;
                mOver = 1;
                for (int i = 0; i < MOLES; i++) mValid[i] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0]              expMap;
        logic [4*SCORE_DIGITS-1:0] expBcd;
        int                        v;
        expMap = '0;
        for (int i = 0; i < MOLES; i++) if (mValid[i]) expMap[mCell[i]] = 1'b1;
        v = mScore;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            expBcd[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        check({tag, ".mole_map"},   32'(bus.mole_map),   32'(expMap));
        check({tag, ".score_bcd"},  32'(bus.score_bcd),  32'(expBcd));
        check({tag, ".time_left"},  32'(bus.time_left),  32'(mTime));
        check({tag, ".miss_count"}, 32'(bus.miss_count), 32'(mMiss));
        check({tag, ".playing"},    32'(bus.playing),    32'(mPlay));
        check({tag, ".game_over"},  32'(bus.game_over),  32'(mOver));
        check({tag, ".hit_ack"},    32'(bus.hit_ack),    32'(mAck));
        check({tag, ".hit_good"},   32'(bus.hit_good),   32'(mGood));
    endtask

    task automatic applyStimulus(input string tag, input bit tSec, input bit tStep,
                                 input bit st, input bit md, input bit hv, input int hc);
        logic [31:0] hcv;
        hcv           = 32'(hc);
        bus.tick_sec  = tSec;
        bus.tick_step = tStep;
        bus.start     = st;
        bus.mode      = md;
        bus.hit_valid = hv;
        bus.hit_cell  = hcv[CW-1:0];
        @(posedge clk);
        modelStep(tSec, tStep, st, md, hv, hc);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset(input string tag);
        rst = 1'b0;
        #2;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic playToScore(input int target, input int extra);
        int done;
        int c;
        done = 0;
        for (int k = 0; k < 8000; k++) begin
            if (mScore >= target && done >= extra) break;
            c = liveCell();
            if (c >= 0) begin
                if (mScore >= target) done++;
                applyStimulus("score_hit", 0, 0, 0, 0, 1, c);
            end else begin
                applyStimulus("score_step", 0, 1, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic randomPlay(input int cycles);
        bit tSec, tStep, st, md, hv;
        int hc;
        for (int k = 0; k < cycles; k++) begin
            tSec  = ($urandom_range(0, 29) == 0);
            tStep = ($urandom_range(0, 2) == 0);
            st    = ($urandom_range(0, 39) == 0);
            md    = 1'($urandom_range(0, 1));
            hv    = 1'($urandom_range(0, 1));
            hc    = liveCell();
            if (hc < 0 || $urandom_range(0, 3) == 0) hc = $urandom_range(0, N - 1);
            applyStimulus("random", tSec, tStep, st, md, hv, hc);
        end
    endtask

    initial begin
        bit hitExpDone;
        int c;
        checks = 0;
        errors = 0;
        bus.tick_sec = 0; bus.tick_step = 0; bus.start = 0;
        bus.mode = 0; bus.hit_valid = 0; bus.hit_cell = '0;
        rst = 1'b1;
        @(negedge clk);
        doReset("reset");
        repeat (2) applyStimulus("idle", 0, 0, 0, 0, 0, 0);
        applyStimulus("idle_hit", 0, 0, 0, 0, 1, 5);

        // Timed countdown from a clean start.
        applyStimulus("timed_start", 0, 0, 1, 0, 0, 0);
        for (int s = 0; s < GAME_SECS; s++) begin
            repeat (2) applyStimulus("timed_wait", 0, 1, 0, 0, 0, 0);
            applyStimulus("timed_sec", 1, 0, 0, 0, 0, 0);
        end
        check("timed_over", 32'(bus.game_over), 32'd1);
        applyStimulus("over_hit", 0, 0, 0, 0, 1, 3);

        // Survival with no hits until the miss limit ends the game.
        applyStimulus("surv_start", 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 300 && mPlay; k++)
            applyStimulus("surv_step", 0, 1, 0, 0, 0, 0);
        check("surv_over", 32'(bus.game_over), 32'd1);

        // Hit landing on a slot in the same cycle it would expire.
        hitExpDone = 0;
        for (int k = 0; k < 300 && !hitExpDone; k++) begin
            if (!mPlay) begin
                applyStimulus("hx_start", 0, 0, 1, 1, 0, 0);
            end else begin
                c = -1;
                for (int i = 0; i < MOLES; i++)
                    if (mValid[i] && mAge[i] == LIFE_TICKS - 1) c = mCell[i];
                if (c >= 0) begin
                    applyStimulus("hit_vs_expire", 0, 1, 0, 0, 1, c);
                    hitExpDone = 1;
                end else begin
                    applyStimulus("hx_step", 0, 1, 0, 0, 0, 0);
                end
            end
        end
        check("hit_vs_expire_reached", 32'(hitExpDone), 32'd1);

        // Score saturation in a survival game that never misses.
        doReset("reset_pre_sat");
        applyStimulus("sat_start", 0, 0, 1, 1, 0, 0);
        playToScore(SCORE_MAX, 4);
        check("score_sat", 32'(bus.score_bcd), 32'h999);

        // Reset in the middle of a game, then a fresh game.
        doReset("reset_pre_mid");
        applyStimulus("mid_start", 0, 0, 1, 1, 0, 0);
        playToScore(7, 0);
        check("score_seven", 32'(bus.score_bcd), 32'h007);
        doReset("reset_mid_game");
        applyStimulus("restart", 0, 0, 1, 0, 0, 0);
        check("restart_score", 32'(bus.score_bcd), 32'h000);

        randomPlay(600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
